// File: rtl/jk_input_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// jk_input_debouncer_pkg : shared debounce state encodings and rate defaults
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package jk_input_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } deb_state_t;

    localparam int DEFAULT_OLD_HZ       = 10;
    localparam int DEFAULT_NEW_HZ       = 1;
    localparam int DEFAULT_STABLE_COUNT = 3;

    // Counter width helper that never returns zero.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

`default_nettype wire

// File: rtl/jk_input_debouncer_debounce_channel.sv
// ---------------------------------------------------------------------------
// jk_input_debouncer_debounce_channel : 2-FF synchronizer + tick-sampled debounce FSM
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jk_input_debouncer_debounce_channel
    import jk_input_debouncer_pkg::*;
#(
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic level_next
);

    localparam int             CW     = $clog2(STABLE_COUNT + 1);
    localparam logic [CW-1:0]  TARGET = CW'(STABLE_COUNT);
    localparam logic [CW-1:0]  ONE    = CW'(1);

    logic          sync_meta;
    logic          sync_out;
    deb_state_t    state;
    deb_state_t    state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOW;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            level <= level_next;
        end
    end

    // cnt counts consecutive opposite samples; it stops short of TARGET
    // because reaching TARGET is the accept event itself.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (tick) begin
            case (state)
                ST_LOW: begin
                    if (sync_out) begin
                        if (STABLE_COUNT == 1) begin
                            state_next = ST_HIGH;
                            cnt_next   = '0;
                        end else begin
                            state_next = ST_WAIT_HIGH;
                            cnt_next   = ONE;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!sync_out) begin
                        state_next = ST_LOW;
                        cnt_next   = '0;
                    end else if (cnt >= TARGET - ONE) begin
                        state_next = ST_HIGH;
                        cnt_next   = '0;
                    end else begin
                        cnt_next   = cnt + ONE;
                    end
                end
                ST_HIGH: begin
                    if (!sync_out) begin
                        if (STABLE_COUNT == 1) begin
                            state_next = ST_LOW;
                            cnt_next   = '0;
                        end else begin
                            state_next = ST_WAIT_LOW;
                            cnt_next   = ONE;
                        end
                    end
                end
                ST_WAIT_LOW: begin
                    if (sync_out) begin
                        state_next = ST_HIGH;
                        cnt_next   = '0;
                    end else if (cnt >= TARGET - ONE) begin
                        state_next = ST_LOW;
                        cnt_next   = '0;
                    end else begin
                        cnt_next   = cnt + ONE;
                    end
                end
                default: begin
                    state_next = ST_LOW;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign level_next = (state_next == ST_HIGH) || (state_next == ST_WAIT_LOW);

endmodule

`default_nettype wire

// File: rtl/jk_input_debouncer.sv
// ---------------------------------------------------------------------------
// jk_input_debouncer : debounced J/K levels, shared change strobe, sample tick
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jk_input_debouncer
    import jk_input_debouncer_pkg::*;
#(
    parameter int pOldHz       = DEFAULT_OLD_HZ,
    parameter int pNewHz       = DEFAULT_NEW_HZ,
    parameter int pStableCount = DEFAULT_STABLE_COUNT
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iJ_raw,
    input  logic iK_raw,
    output logic oJ,
    output logic oK,
    output logic oChange,
    output logic oTick
);

    localparam int            DIV      = pOldHz / pNewHz;
    localparam int            DW       = clog2_min1(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_cnt_next;
    logic          j_next;
    logic          k_next;

    always_comb begin
        div_cnt_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
    end

    // Tick is registered off the next count so it is low during reset and
    // still goes permanently high when DIV is 1.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            div_cnt <= '0;
            oTick   <= 1'b0;
        end else begin
            div_cnt <= div_cnt_next;
            oTick   <= (div_cnt_next == DIV_LAST);
        end
    end

    jk_input_debouncer_debounce_channel #(
        .STABLE_COUNT (pStableCount)
    ) u_j_channel (
        .clk        (iClk),
        .rst_n      (iReset),
        .tick       (oTick),
        .raw        (iJ_raw),
        .level      (oJ),
        .level_next (j_next)
    );

    jk_input_debouncer_debounce_channel #(
        .STABLE_COUNT (pStableCount)
    ) u_k_channel (
        .clk        (iClk),
        .rst_n      (iReset),
        .tick       (oTick),
        .raw        (iK_raw),
        .level      (oK),
        .level_next (k_next)
    );

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            oChange <= 1'b0;
        end else begin
            oChange <= (j_next != oJ) || (k_next != oK);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jk_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_jk_input_debouncer : directed stimulus against a sample-history model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jk_input_debouncer;

    localparam int DIV = 10;
    localparam int S   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic j_raw = 1'b0;
    logic k_raw = 1'b0;
    logic o_j, o_k, o_change, o_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_input_debouncer #(
        .pOldHz       (10),
        .pNewHz       (1),
        .pStableCount (S)
    ) dut (
        .iClk    (clk),
        .iReset  (rst_n),
        .iJ_raw  (j_raw),
        .iK_raw  (k_raw),
        .oJ      (o_j),
        .oK      (o_k),
        .oChange (o_change),
        .oTick   (o_tick)
    );

    // Model: edges since release, raw values delayed two edges, last S tick
    // samples per channel; output flips when all last S samples disagree.
    int cyc = 0;
    bit m_j, m_k, m_chg, m_tick;
    bit j_d1, j_d2, k_d1, k_d2;
    bit jh [S];
    bit kh [S];

    function automatic bit all_differ(input bit h [S], input bit cur);
        for (int i = 0; i < S; i++) if (h[i] == cur) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            m_j = 0; m_k = 0; m_chg = 0; m_tick = 0;
            j_d1 = 0; j_d2 = 0; k_d1 = 0; k_d2 = 0;
            for (int i = 0; i < S; i++) begin jh[i] = 0; kh[i] = 0; end
        end else begin
            bit sj, sk;
            cyc++;
            sj = j_d2; j_d2 = j_d1; j_d1 = j_raw;
            sk = k_d2; k_d2 = k_d1; k_d1 = k_raw;
            m_chg = 0;
            if (cyc % DIV == 0) begin
                for (int i = S - 1; i > 0; i--) begin jh[i] = jh[i-1]; kh[i] = kh[i-1]; end
                jh[0] = sj;
                kh[0] = sk;
                if (all_differ(jh, m_j)) begin m_j = ~m_j; m_chg = 1; end
                if (all_differ(kh, m_k)) begin m_k = ~m_k; m_chg = 1; end
            end
            m_tick = ((cyc + 1) % DIV == 0);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b cyc=%0d t=%0t", name, act, exp, cyc, $time);
        end
    endtask

    always @(negedge clk) begin
        check("oJ", o_j, m_j);
        check("oK", o_k, m_k);
        check("oChange", o_change, m_chg);
        check("oTick", o_tick, m_tick);
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc actual=%0d expected=%0d", cyc, n);
        end
    endtask

    initial begin
        // 1: reset then first tick
        #1 rst_n = 1'b0;
        #169 rst_n = 1'b1;
        wait_cyc(8);  check("lit_tick_8", o_tick, 1'b0);
        wait_cyc(9);  check("lit_tick_9", o_tick, 1'b1);
        wait_cyc(10); check("lit_tick_10", o_tick, 1'b0);

        // 2: clean J rise, accepted on ticks 20/30/40
        j_raw = 1'b1;
        wait_cyc(39); check("lit_j_39", o_j, 1'b0);
        wait_cyc(40); check("lit_j_40", o_j, 1'b1);
        check("lit_chg_40", o_change, 1'b1);
        check("lit_k_40", o_k, 1'b0);
        wait_cyc(41); check("lit_chg_41", o_change, 1'b0);
        j_raw = 1'b0;
        wait_cyc(69); check("lit_j_69", o_j, 1'b1);
        wait_cyc(70); check("lit_j_70", o_j, 1'b0);

        // 3: one-tick-wide J pulse is rejected
        j_raw = 1'b1;
        wait_cyc(80); j_raw = 1'b0;
        wait_cyc(95); check("lit_j_95", o_j, 1'b0);

        // 4: K bounces every 2 clocks, then settles high
        for (int m = 100; m < 140; m += 2) begin
            wait_cyc(m);
            k_raw = logic'(((m - 100) / 2) % 2);
        end
        wait_cyc(140); k_raw = 1'b1;
        wait_cyc(169); check("lit_k_169", o_k, 1'b0);
        wait_cyc(170); check("lit_k_170", o_k, 1'b1);
        check("lit_chg_170", o_change, 1'b1);
        wait_cyc(171); k_raw = 1'b0;

        // 5: J and K together
        wait_cyc(200); check("lit_k_200", o_k, 1'b0);
        j_raw = 1'b1; k_raw = 1'b1;
        wait_cyc(229); check("lit_jk_229", o_j | o_k, 1'b0);
        wait_cyc(230); check("lit_j_230", o_j, 1'b1);
        check("lit_k_230", o_k, 1'b1);
        check("lit_chg_230", o_change, 1'b1);
        wait_cyc(231); check("lit_chg_231", o_change, 1'b0);
        j_raw = 1'b0; k_raw = 1'b0;

        // 6: reset pulse while J is two samples into its wait
        wait_cyc(260); check("lit_j_260", o_j, 1'b0);
        j_raw = 1'b1;
        wait_cyc(281);
        #1 rst_n = 1'b0;
        #1 check("lit_rst_j", o_j, 1'b0);
        check("lit_rst_tick", o_tick, 1'b0);
        #2 rst_n = 1'b1;
        wait_cyc(29); check("lit_j_post_29", o_j, 1'b0);
        wait_cyc(30); check("lit_j_post_30", o_j, 1'b1);
        check("lit_chg_post_30", o_change, 1'b1);
        wait_cyc(35);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
